// File: rtl/ofm_write_addr_gen_pkg.sv
// Shared types and constants for the OFM write address generator.
// Holds the FSM encoding, the latched layer config struct and the config code values.
package ofm_write_addr_gen_pkg;

  localparam int OFM_RAM_SIZE_DEF = 2378675;
  localparam int AW_DEF           = $clog2(OFM_RAM_SIZE_DEF);
  localparam int DATA_WIDTH_DEF   = 64;

  localparam logic [1:0] KERNEL_3 = 2'd3;
  localparam logic [1:0] STRIDE_2 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RUN   = 3'd2,
    ST_REPL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [8:0]  ifm_size;
    logic [1:0]  kernel_size;
    logic [10:0] num_filter;
    logic        maxpool_mode;
    logic [1:0]  maxpool_stride;
    logic        upsample_mode;
  } layer_cfg_t;

endpackage

// File: rtl/ofm_write_addr_gen_if.sv
// Layer config, PE-array result stream and OFM RAM write port of the address generator.
// The generator sits on the slave side; the layer sequencer / PE array / RAM side is master.
interface ofm_write_addr_gen_if #(
  parameter int AW         = ofm_write_addr_gen_pkg::AW_DEF,
  parameter int DATA_WIDTH = ofm_write_addr_gen_pkg::DATA_WIDTH_DEF
);

  logic                  start_layer;
  logic [8:0]            ifm_size;
  logic [1:0]            kernel_size;
  logic [10:0]           num_filter;
  logic                  maxpool_mode;
  logic [1:0]            maxpool_stride;
  logic                  upsample_mode;
  logic [AW-1:0]         start_write_addr;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  done_layer;
  logic                  busy;

  modport master (
    output start_layer, ifm_size, kernel_size, num_filter, maxpool_mode,
           maxpool_stride, upsample_mode, start_write_addr, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, done_layer, busy
  );

  modport slave (
    input  start_layer, ifm_size, kernel_size, num_filter, maxpool_mode,
           maxpool_stride, upsample_mode, start_write_addr, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, done_layer, busy
  );

endinterface

// File: rtl/ofm_dim_calc.sv
// Output-plane side lengths from the latched layer config: S_in words per row in, S_out per row out.
// Purely combinational, no backpressure.
module ofm_dim_calc
  import ofm_write_addr_gen_pkg::*;
(
  input  logic [8:0] ifm_size,
  input  logic [1:0] kernel_size,
  input  logic       maxpool_mode,
  input  logic [1:0] maxpool_stride,
  input  logic       upsample_mode,
  output logic [8:0] s_in,
  output logic [9:0] s_out
);

  logic [8:0] conv;

  always_comb begin
    conv = ifm_size;
    // A 3x3 kernel on an image smaller than 2 yields an empty plane rather than a wrapped size.
    if (kernel_size == KERNEL_3) begin
      conv = (ifm_size >= 9'd2) ? (ifm_size - 9'd2) : 9'd0;
    end
    s_in  = (maxpool_mode && (maxpool_stride == STRIDE_2)) ? {1'b0, conv[8:1]} : conv;
    s_out = upsample_mode ? {s_in, 1'b0} : {1'b0, s_in};
  end

endmodule

// File: rtl/ofm_write_addr_gen.sv
// Turns the PE-array result stream into OFM RAM writes (c, then r, then filter order), optionally 2x upsampled.
// One cycle accept-to-write; in_ready only in RUN, so upsample holds the stream off for 3 of every 4 cycles.
module ofm_write_addr_gen
  import ofm_write_addr_gen_pkg::*;
#(
  parameter int OFM_RAM_SIZE = OFM_RAM_SIZE_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF
)
(
  input  logic                   clk,
  input  logic                   rst,
  ofm_write_addr_gen_if.slave    io
);

  localparam int AW = $clog2(OFM_RAM_SIZE);

  state_t                state, state_nxt;
  layer_cfg_t            cfg_q;
  logic [AW-1:0]         start_addr_q;

  logic [8:0]            col, row;
  logic [10:0]           filt;
  logic [1:0]            phase;
  logic [AW-1:0]         row_base;

  logic                  wr_en_q;
  logic [AW-1:0]         wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic [8:0]            s_in;
  logic [9:0]            s_out;

  logic                  accept, word_end, last_word;
  logic                  col_last, row_last, filt_last;
  logic [9:0]            col_off;
  logic [10:0]           row_step;
  logic [AW-1:0]         addr_nxt;

  ofm_dim_calc u_dim_calc (
    .ifm_size       (cfg_q.ifm_size),
    .kernel_size    (cfg_q.kernel_size),
    .maxpool_mode   (cfg_q.maxpool_mode),
    .maxpool_stride (cfg_q.maxpool_stride),
    .upsample_mode  (cfg_q.upsample_mode),
    .s_in           (s_in),
    .s_out          (s_out)
  );

  assign accept    = (state == ST_RUN) && io.in_valid;
  assign col_last  = (col == s_in - 9'd1);
  assign row_last  = (row == s_in - 9'd1);
  assign filt_last = (filt == cfg_q.num_filter - 11'd1);
  assign last_word = col_last && row_last && filt_last;
  assign word_end  = cfg_q.upsample_mode ? ((state == ST_REPL) && (phase == 2'd3)) : accept;

  // row_base steps by one output row (two when upsampling); stepping past the last row lands on the next plane.
  assign col_off   = cfg_q.upsample_mode ? {col, 1'b0} : {1'b0, col};
  assign row_step  = cfg_q.upsample_mode ? {s_out, 1'b0} : {1'b0, s_out};
  assign addr_nxt  = row_base + {{(AW-10){1'b0}}, col_off}
                   + (phase[1] ? {{(AW-10){1'b0}}, s_out} : '0)
                   + {{(AW-1){1'b0}}, phase[0]};

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (io.start_layer) state_nxt = ST_SETUP;
      ST_SETUP: state_nxt = ((s_in == 9'd0) || (cfg_q.num_filter == 11'd0)) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (accept) begin
          if (cfg_q.upsample_mode) state_nxt = ST_REPL;
          else if (last_word)      state_nxt = ST_DONE;
        end
      end
      ST_REPL:  if (phase == 2'd3) state_nxt = last_word ? ST_DONE : ST_RUN;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q        <= '0;
      start_addr_q <= '0;
      col          <= '0;
      row          <= '0;
      filt         <= '0;
      phase        <= '0;
      row_base     <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      if ((state == ST_IDLE) && io.start_layer) begin
        cfg_q.ifm_size       <= io.ifm_size;
        cfg_q.kernel_size    <= io.kernel_size;
        cfg_q.num_filter     <= io.num_filter;
        cfg_q.maxpool_mode   <= io.maxpool_mode;
        cfg_q.maxpool_stride <= io.maxpool_stride;
        cfg_q.upsample_mode  <= io.upsample_mode;
        start_addr_q         <= io.start_write_addr;
      end

      if (state == ST_SETUP) begin
        col      <= '0;
        row      <= '0;
        filt     <= '0;
        phase    <= '0;
        row_base <= start_addr_q;
      end

      wr_en_q <= accept || (state == ST_REPL);
      if (accept || (state == ST_REPL)) wr_addr_q <= addr_nxt;
      if (accept) wr_data_q <= io.in_data;

      if (accept && cfg_q.upsample_mode) phase <= 2'd1;
      else if (state == ST_REPL)         phase <= phase + 2'd1;

      if (word_end) begin
        if (!col_last) begin
          col <= col + 9'd1;
        end else begin
          col      <= '0;
          row_base <= row_base + {{(AW-11){1'b0}}, row_step};
          if (!row_last) begin
            row <= row + 9'd1;
          end else begin
            row  <= '0;
            filt <= filt + 11'd1;
          end
        end
      end
    end
  end

  assign io.in_ready   = (state == ST_RUN);
  assign io.busy       = (state != ST_IDLE);
  assign io.done_layer = (state == ST_DONE);
  assign io.wr_en      = wr_en_q;
  assign io.wr_addr    = wr_addr_q;
  assign io.wr_data    = wr_data_q;

endmodule

// File: tb/tb_ofm_write_addr_gen.sv
// Directed bench for ofm_write_addr_gen: normal, gapped, upsampled, pooled, aborted and empty layers.
module tb_ofm_write_addr_gen;

  localparam int AW = 22;
  localparam int DW = 64;
  localparam logic [DW-1:0] DATA_TAG = 64'hDEAD_BEEF_0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ofm_write_addr_gen_if #(.AW(AW), .DATA_WIDTH(DW)) bus ();

  ofm_write_addr_gen #(.OFM_RAM_SIZE(2378675), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];
  int            wq_cyc[$];
  int            done_cyc[$];
  int            acc_cnt, first_acc_cyc, last_acc_cyc, rdy_hi, rdy_lo;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wq_addr.push_back(bus.wr_addr);
      wq_data.push_back(bus.wr_data);
      wq_cyc.push_back(cyc);
    end
    if (bus.done_layer === 1'b1) done_cyc.push_back(cyc);
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
      if (acc_cnt == 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
      acc_cnt++;
    end
    if (bus.busy === 1'b1) begin
      if (bus.in_ready === 1'b1) rdy_hi++;
      else                       rdy_lo++;
    end
  end

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); done_cyc.delete();
    acc_cnt = 0; first_acc_cyc = -1; last_acc_cyc = -1; rdy_hi = 0; rdy_lo = 0;
  endtask

  function automatic logic [AW-1:0] exp_addr(input int k, input int s, input bit up, input int sa);
    int i, sub, c, r, f, so;
    longint a;
    if (up) begin i = k / 4; sub = k % 4; so = 2 * s; end
    else    begin i = k;     sub = 0;     so = s;     end
    c = i % s; r = (i / s) % s; f = i / (s * s);
    if (up) begin r = 2 * r + sub / 2; c = 2 * c + sub % 2; end
    a = longint'(sa) + longint'(f) * so * so + longint'(r) * so + longint'(c);
    return a[AW-1:0];
  endfunction

  task automatic set_cfg(input logic [8:0] ifm, input logic [1:0] k, input logic [10:0] nf,
                         input logic mp, input logic [1:0] ms, input logic up, input logic [AW-1:0] sa);
    bus.ifm_size = ifm; bus.kernel_size = k; bus.num_filter = nf; bus.maxpool_mode = mp;
    bus.maxpool_stride = ms; bus.upsample_mode = up; bus.start_write_addr = sa;
  endtask

  // Starts a layer, scrambles the config pins, then streams nwords words with optional gaps.
  task automatic drive_layer(input logic [8:0] ifm, input logic [1:0] k, input logic [10:0] nf,
                             input logic mp, input logic [1:0] ms, input logic up, input logic [AW-1:0] sa,
                             input int nwords, input int gap_pct, input int stray_at, input int max_cyc,
                             output logic timed_out);
    int idx = 0;
    int n = 0;
    logic acc;
    @(posedge clk); #1;
    set_cfg(ifm, k, nf, mp, ms, up, sa);
    bus.start_layer = 1'b1;
    @(posedge clk); #1;
    bus.start_layer = 1'b0;
    set_cfg(9'd0, 2'd0, 11'd0, 1'b0, 2'd0, 1'b0, '0);
    while (idx < nwords && n < max_cyc) begin
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      bus.in_data  = DATA_TAG ^ 64'(idx);
      if (idx == stray_at) begin
        bus.start_layer = 1'b1;
        set_cfg(9'd3, 2'd1, 11'd1, 1'b0, 2'd0, 1'b0, 22'd5);
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      bus.start_layer = 1'b0;
      if (acc) idx++;
      n++;
    end
    bus.in_valid = 1'b0;
    for (int w = 0; w < 20 && done_cyc.size() == 0; w++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    timed_out = (idx < nwords) || (done_cyc.size() == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_layer = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    set_cfg(9'd0, 2'd0, 11'd0, 1'b0, 2'd0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", bus.wr_en); else pass_cnt++;
    total_cnt++; if (bus.done_layer !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done_layer); else pass_cnt++;
    total_cnt++; if (bus.wr_addr !== '0) $display("FAIL rst_wr_addr: got %0d want 0", bus.wr_addr); else pass_cnt++;
    total_cnt++; if (bus.wr_data !== '0) $display("FAIL rst_wr_data: got %h want 0", bus.wr_data); else pass_cnt++;
  endtask

  task automatic test_normal();
    logic to;
    int errs = 0;
    int first_bad = -1;
    clear_mon();
    drive_layer(9'd6, 2'd3, 11'd16, 1'b0, 2'd0, 1'b0, 22'd526656, 256, 0, -1, 2000, to);
    total_cnt++; if (to !== 1'b0) $display("FAIL norm_timeout: got %b want 0", to); else pass_cnt++;
    total_cnt++; if (wq_addr.size() !== 256) $display("FAIL norm_wr_count: got %0d want 256", wq_addr.size()); else pass_cnt++;
    for (int k = 0; k < wq_addr.size() && k < 256; k++)
      if (wq_addr[k] !== 22'd526656 + 22'(k) || wq_data[k] !== (DATA_TAG ^ 64'(k))) begin
        errs++; if (first_bad < 0) first_bad = k;
      end
    total_cnt++; if (errs !== 0) $display("FAIL norm_seq: %0d bad writes (first %0d), want 0", errs, first_bad); else pass_cnt++;
    total_cnt++; if (wq_addr.size() > 0 && wq_cyc[0] !== first_acc_cyc + 1)
      $display("FAIL norm_latency: first write cyc %0d want %0d", wq_cyc[0], first_acc_cyc + 1); else pass_cnt++;
    total_cnt++; if (done_cyc.size() !== 1) $display("FAIL norm_done_count: got %0d want 1", done_cyc.size()); else pass_cnt++;
    total_cnt++; if (done_cyc.size() > 0 && done_cyc[0] !== last_acc_cyc + 1)
      $display("FAIL norm_done_cyc: got %0d want %0d", done_cyc[0], last_acc_cyc + 1); else pass_cnt++;
    total_cnt++; if (rdy_hi !== 256) $display("FAIL norm_ready_cycles: got %0d want 256", rdy_hi); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL norm_idle_after: busy %b want 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_gaps();
    logic to;
    int errs = 0;
    clear_mon();
    drive_layer(9'd6, 2'd3, 11'd16, 1'b0, 2'd0, 1'b0, 22'd526656, 256, 50, 100, 3000, to);
    total_cnt++; if (to !== 1'b0) $display("FAIL gap_timeout: got %b want 0", to); else pass_cnt++;
    total_cnt++; if (wq_addr.size() !== 256) $display("FAIL gap_wr_count: got %0d want 256", wq_addr.size()); else pass_cnt++;
    for (int k = 0; k < wq_addr.size() && k < 256; k++)
      if (wq_addr[k] !== 22'd526656 + 22'(k) || wq_data[k] !== (DATA_TAG ^ 64'(k))) errs++;
    total_cnt++; if (errs !== 0) $display("FAIL gap_seq: %0d bad writes, want 0", errs); else pass_cnt++;
    total_cnt++; if (done_cyc.size() !== 1) $display("FAIL gap_done_count: got %0d want 1", done_cyc.size()); else pass_cnt++;
    total_cnt++; if (acc_cnt !== 256) $display("FAIL gap_accepts: got %0d want 256", acc_cnt); else pass_cnt++;
  endtask

  task automatic test_upsample();
    logic to;
    int errs = 0;
    int first_bad = -1;
    clear_mon();
    drive_layer(9'd13, 2'd1, 11'd2, 1'b0, 2'd0, 1'b1, 22'd1773655, 338, 0, -1, 4000, to);
    total_cnt++; if (to !== 1'b0) $display("FAIL up_timeout: got %b want 0", to); else pass_cnt++;
    total_cnt++; if (wq_addr.size() !== 1352) $display("FAIL up_wr_count: got %0d want 1352", wq_addr.size()); else pass_cnt++;
    if (wq_addr.size() >= 4) begin
      total_cnt++; if (wq_addr[0] !== 22'd1773655) $display("FAIL up_w0: got %0d want 1773655", wq_addr[0]); else pass_cnt++;
      total_cnt++; if (wq_addr[1] !== 22'd1773656) $display("FAIL up_w1: got %0d want 1773656", wq_addr[1]); else pass_cnt++;
      total_cnt++; if (wq_addr[2] !== 22'd1773681) $display("FAIL up_w2: got %0d want 1773681", wq_addr[2]); else pass_cnt++;
      total_cnt++; if (wq_addr[3] !== 22'd1773682) $display("FAIL up_w3: got %0d want 1773682", wq_addr[3]); else pass_cnt++;
      total_cnt++; if (wq_data[3] !== DATA_TAG) $display("FAIL up_w3_data: got %h want %h", wq_data[3], DATA_TAG); else pass_cnt++;
      total_cnt++; if (wq_addr[wq_addr.size()-1] !== 22'd1775006)
        $display("FAIL up_last_addr: got %0d want 1775006", wq_addr[wq_addr.size()-1]); else pass_cnt++;
    end else begin
      total_cnt++; $display("FAIL up_first_words: got %0d writes want at least 4", wq_addr.size());
    end
    for (int k = 0; k < wq_addr.size() && k < 1352; k++)
      if (wq_addr[k] !== exp_addr(k, 13, 1'b1, 1773655) || wq_data[k] !== (DATA_TAG ^ 64'(k / 4))) begin
        errs++; if (first_bad < 0) first_bad = k;
      end
    total_cnt++; if (errs !== 0) $display("FAIL up_seq: %0d bad writes (first %0d), want 0", errs, first_bad); else pass_cnt++;
    total_cnt++; if (rdy_hi !== 338) $display("FAIL up_ready_hi: got %0d want 338", rdy_hi); else pass_cnt++;
    total_cnt++; if (rdy_lo !== 1016) $display("FAIL up_ready_lo: got %0d want 1016", rdy_lo); else pass_cnt++;
    total_cnt++; if (done_cyc.size() !== 1) $display("FAIL up_done_count: got %0d want 1", done_cyc.size()); else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    clear_mon();
    @(posedge clk); #1;
    set_cfg(9'd318, 2'd3, 11'd16, 1'b1, 2'd2, 1'b0, '0);
    bus.start_layer = 1'b1;
    @(posedge clk); #1;
    bus.start_layer = 1'b0;
    while (acc_cnt < 300 && n < 1000) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_TAG ^ 64'(acc_cnt);
      @(posedge clk); #1;
      n++;
    end
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (acc_cnt !== 300) $display("FAIL abort_accepts: got %0d want 300", acc_cnt); else pass_cnt++;
    total_cnt++; if ({bus.busy, bus.in_ready, bus.wr_en, bus.done_layer} !== 4'b0)
      $display("FAIL abort_flags: busy/rdy/wr_en/done got %b want 0000", {bus.busy, bus.in_ready, bus.wr_en, bus.done_layer}); else pass_cnt++;
    total_cnt++; if (bus.wr_addr !== '0 || bus.wr_data !== '0)
      $display("FAIL abort_bus: addr %0d data %h want 0", bus.wr_addr, bus.wr_data); else pass_cnt++;
    rst = 1'b0;
    bus.in_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    total_cnt++; if (wq_addr.size() !== 300) $display("FAIL abort_writes: got %0d want 300", wq_addr.size()); else pass_cnt++;
    total_cnt++; if (done_cyc.size() !== 0) $display("FAIL abort_done: got %0d pulses want 0", done_cyc.size()); else pass_cnt++;
  endtask

  task automatic test_pool();
    logic to;
    int errs = 0;
    clear_mon();
    drive_layer(9'd318, 2'd3, 11'd1, 1'b1, 2'd2, 1'b0, '0, 24964, 0, -1, 26000, to);
    total_cnt++; if (to !== 1'b0) $display("FAIL pool_timeout: got %b want 0", to); else pass_cnt++;
    total_cnt++; if (wq_addr.size() !== 24964) $display("FAIL pool_wr_count: got %0d want 24964", wq_addr.size()); else pass_cnt++;
    for (int k = 0; k < wq_addr.size() && k < 24964; k++)
      if (wq_addr[k] !== exp_addr(k, 158, 1'b0, 0)) errs++;
    total_cnt++; if (errs !== 0) $display("FAIL pool_seq: %0d bad writes, want 0", errs); else pass_cnt++;
    total_cnt++; if (wq_addr.size() > 0 && wq_addr[wq_addr.size()-1] !== 22'd24963)
      $display("FAIL pool_last_addr: got %0d want 24963", wq_addr[wq_addr.size()-1]); else pass_cnt++;
    total_cnt++; if (done_cyc.size() !== 1) $display("FAIL pool_done_count: got %0d want 1", done_cyc.size()); else pass_cnt++;
  endtask

  task automatic test_empty(input logic [8:0] ifm, input logic [10:0] nf, input string tag);
    int sc;
    clear_mon();
    @(posedge clk); #1;
    set_cfg(ifm, 2'd3, nf, 1'b0, 2'd0, 1'b0, 22'd100);
    bus.start_layer = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    bus.start_layer = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total_cnt++; if (done_cyc.size() !== 1) $display("FAIL %s_done_count: got %0d want 1", tag, done_cyc.size()); else pass_cnt++;
    total_cnt++; if (done_cyc.size() > 0 && done_cyc[0] !== sc + 2)
      $display("FAIL %s_done_cyc: got %0d want %0d", tag, done_cyc[0], sc + 2); else pass_cnt++;
    total_cnt++; if (wq_addr.size() !== 0) $display("FAIL %s_writes: got %0d want 0", tag, wq_addr.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_gaps();
    test_upsample();
    test_reset_midrun();
    test_pool();
    test_empty(9'd6, 11'd0, "nf0");
    test_empty(9'd2, 11'd4, "sin0");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
